// File: rtl/dict_decompressor.sv
// Loads the dictionary (LOAD), then expands tokens via a dictionary lookup or as literals (RUN). Latency 1 cycle.
// A single output register gives full rate with a valid/ready handshake; tok_ready stays low while a held word is stalled.
module dict_decompressor #(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic [VAL_WIDTH-1:0] ld_data,
  output logic                 dict_we,
  output logic [VAL_WIDTH-1:0] dict_wval,
  output logic [KEY_WIDTH-1:0] dict_key,
  input  logic [VAL_WIDTH-1:0] dict_val,
  output logic                 dict_ready,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic                 tok_cmp,
  input  logic [VAL_WIDTH-1:0] tok_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VAL_WIDTH-1:0] out_data,
  output logic                 out_was_cmp,
  output logic [CNT_WIDTH-1:0] n_cmp,
  output logic [CNT_WIDTH-1:0] n_lit
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [KEY_WIDTH-1:0] LAST_ENTRY = '1;

  state_t               state;
  logic [KEY_WIDTH-1:0] ld_cnt;
  logic                 tok_acc;

  // Gating with rst_n drops write enable during reset, which restarts the dictionary's write index.
  assign dict_we    = rst_n && (state == LOAD) && ld_valid;
  assign dict_wval  = ld_data;
  assign dict_key   = tok_data[KEY_WIDTH-1:0];
  assign dict_ready = (state == RUN);
  assign tok_ready  = (state == RUN) && (!out_valid || out_ready);
  assign tok_acc    = tok_valid && tok_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      ld_cnt      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_was_cmp <= 1'b0;
      n_cmp       <= '0;
      n_lit       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_valid) begin
            if (ld_cnt == LAST_ENTRY) begin
              state  <= RUN;
              ld_cnt <= '0;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end else begin
            // A gap aborts a partial load; upstream resends from entry 0.
            ld_cnt <= '0;
          end
        end
        RUN: begin
          if (tok_acc) begin
            out_valid   <= 1'b1;
            out_data    <= tok_cmp ? dict_val : tok_data;
            out_was_cmp <= tok_cmp;
            if (tok_cmp) begin
              if (n_cmp != '1) n_cmp <= n_cmp + 1'b1;
            end else begin
              if (n_lit != '1) n_lit <= n_lit + 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_decompressor.sv
// Directed bench for dict_decompressor with a behavioural auto-incrementing dictionary attached.
module tb_dict_decompressor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       dict_we;
  logic [7:0] dict_wval;
  logic [3:0] dict_key;
  logic [7:0] dict_val;
  logic       dict_ready;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic       tok_cmp = 1'b0;
  logic [7:0] tok_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_was_cmp;
  logic [15:0] n_cmp;
  logic [15:0] n_lit;

  int tests = 0;
  int fails = 0;

  dict_decompressor #(.KEY_WIDTH(4), .VAL_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .dict_we(dict_we), .dict_wval(dict_wval), .dict_key(dict_key), .dict_val(dict_val),
    .dict_ready(dict_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_cmp(tok_cmp), .tok_data(tok_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_was_cmp(out_was_cmp),
    .n_cmp(n_cmp), .n_lit(n_lit)
  );

  always #5 clk = ~clk;

  // Dictionary model: write index auto-increments on write, restarts whenever write enable is low.
  logic [7:0] mem [16];
  logic [3:0] wi = 4'd0;
  always @(posedge clk) begin
    if (dict_we) begin
      mem[wi] <= dict_wval;
      wi <= wi + 4'd1;
    end else begin
      wi <= 4'd0;
    end
  end
  assign dict_val = mem[dict_key];

  task automatic load_words(input logic [7:0] base, input bit a5_at3,
                            output int we_cnt, output logic rdy_before);
    we_cnt = 0;
    rdy_before = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = (a5_at3 && i == 3) ? 8'hA5 : base + 8'(i);
      #1;
      if (dict_we) we_cnt++;
      if (dict_ready) rdy_before = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ld_valid = 1'b1; tok_valid = 1'b1; out_ready = 1'b1;
    #12;
    tests++; if (dict_we !== 1'b0) begin fails++; $display("FAIL reset_dict_we got %b want 0", dict_we); end
    tests++; if (dict_ready !== 1'b0) begin fails++; $display("FAIL reset_dict_ready got %b want 0", dict_ready); end
    tests++; if (tok_ready !== 1'b0) begin fails++; $display("FAIL reset_tok_ready got %b want 0", tok_ready); end
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_was_cmp !== 1'b0) begin
      fails++; $display("FAIL reset_out got v=%b d=%h c=%b want 0 00 0", out_valid, out_data, out_was_cmp); end
    tests++; if (n_cmp !== 16'd0 || n_lit !== 16'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", n_cmp, n_lit); end
    ld_valid = 1'b0; tok_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_load;
    int we_cnt;
    logic rdy_before;
    load_words(8'h10, 1'b0, we_cnt, rdy_before);
    ld_valid = 1'b0;
    #1;
    tests++; if (we_cnt != 16) begin fails++; $display("FAIL load_we_cycles got %0d want 16", we_cnt); end
    tests++; if (rdy_before !== 1'b0) begin fails++; $display("FAIL load_ready_early got %b want 0", rdy_before); end
    tests++; if (dict_ready !== 1'b1 || tok_ready !== 1'b1) begin
      fails++; $display("FAIL load_ready_17th got rdy=%b tok_rdy=%b want 1 1", dict_ready, tok_ready); end
    tests++; if (mem[0] !== 8'h10 || mem[15] !== 8'h1F) begin
      fails++; $display("FAIL load_contents got %h/%h want 10/1f", mem[0], mem[15]); end
  endtask

  task automatic test_load_ignored_in_run;
    ld_valid = 1'b1; ld_data = 8'hEE;
    #1;
    tests++; if (dict_we !== 1'b0) begin fails++; $display("FAIL run_dict_we got %b want 0", dict_we); end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    tests++; if (mem[0] !== 8'h10) begin fails++; $display("FAIL run_no_write got %h want 10", mem[0]); end
  endtask

  task automatic test_gap_and_early_tokens;
    int we_cnt;
    logic rdy_before;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tok_valid = 1'b1; tok_cmp = 1'b0; tok_data = 8'h55; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 8'h20 + 8'(i);
      #1;
      tests++; if (tok_ready !== 1'b0) begin fails++; $display("FAIL early_tok_ready[%0d] got %b want 0", i, tok_ready); end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    #1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || n_lit !== 16'd0 || n_cmp !== 16'd0) begin
      fails++; $display("FAIL early_no_output got v=%b lit=%0d cmp=%0d want 0 0 0", out_valid, n_lit, n_cmp); end
    tok_valid = 1'b0;
    load_words(8'h40, 1'b1, we_cnt, rdy_before);
    ld_valid = 1'b0;
    #1;
    tests++; if (rdy_before !== 1'b0) begin fails++; $display("FAIL gap_ready_early got %b want 0", rdy_before); end
    tests++; if (dict_ready !== 1'b1) begin fails++; $display("FAIL gap_ready got %b want 1", dict_ready); end
    tests++; if (mem[0] !== 8'h40 || mem[3] !== 8'hA5) begin
      fails++; $display("FAIL gap_contents got %h/%h want 40/a5", mem[0], mem[3]); end
  endtask

  task automatic test_expand;
    out_ready = 1'b1; tok_valid = 1'b1; tok_cmp = 1'b1; tok_data = 8'h03;
    #1;
    tests++; if (tok_ready !== 1'b1 || dict_key !== 4'h3) begin
      fails++; $display("FAIL expand_accept got rdy=%b key=%h want 1 3", tok_ready, dict_key); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_was_cmp !== 1'b1) begin
      fails++; $display("FAIL expand_cmp got v=%b d=%h c=%b want 1 a5 1", out_valid, out_data, out_was_cmp); end
    tok_cmp = 1'b0; tok_data = 8'h7E;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h7E || out_was_cmp !== 1'b0) begin
      fails++; $display("FAIL expand_lit got v=%b d=%h c=%b want 1 7e 0", out_valid, out_data, out_was_cmp); end
    tests++; if (n_cmp !== 16'd1 || n_lit !== 16'd1) begin
      fails++; $display("FAIL expand_counters got %0d/%0d want 1/1", n_cmp, n_lit); end
    tok_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL expand_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    tok_valid = 1'b1; tok_cmp = 1'b1; tok_data = 8'hF5;
    @(posedge clk); #1;
    tests++; if (out_data !== 8'h45 || out_was_cmp !== 1'b1) begin
      fails++; $display("FAIL b2b_upper_ignored got d=%h c=%b want 45 1", out_data, out_was_cmp); end
    tok_cmp = 1'b0; tok_data = 8'h03;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h03 || out_was_cmp !== 1'b0) begin
      fails++; $display("FAIL b2b_literal got v=%b d=%h c=%b want 1 03 0", out_valid, out_data, out_was_cmp); end
    tok_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || n_cmp !== 16'd2 || n_lit !== 16'd2) begin
      fails++; $display("FAIL b2b_end got v=%b cmp=%0d lit=%0d want 0 2 2", out_valid, n_cmp, n_lit); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1; tok_valid = 1'b1; tok_cmp = 1'b0; tok_data = 8'h11;
    @(posedge clk); #1;
    out_ready = 1'b0; tok_cmp = 1'b1; tok_data = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (tok_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11 || out_was_cmp !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h c=%b want 0 1 11 0", i, tok_ready, out_valid, out_data, out_was_cmp); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    tests++; if (tok_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", tok_ready); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h42 || out_was_cmp !== 1'b1) begin
      fails++; $display("FAIL bp_next got v=%b d=%h c=%b want 1 42 1", out_valid, out_data, out_was_cmp); end
    tok_cmp = 1'b0; tok_data = 8'h33;
    @(posedge clk); #1;
    tests++; if (out_data !== 8'h33 || out_was_cmp !== 1'b0) begin
      fails++; $display("FAIL bp_third got d=%h c=%b want 33 0", out_data, out_was_cmp); end
    tok_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || n_cmp !== 16'd3 || n_lit !== 16'd4) begin
      fails++; $display("FAIL bp_counters got v=%b cmp=%0d lit=%0d want 0 3 4", out_valid, n_cmp, n_lit); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0; tok_valid = 1'b1; tok_cmp = 1'b1; tok_data = 8'h03;
    @(posedge clk); #1;
    tok_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pending got %b want 1", out_valid); end
    ld_valid = 1'b1; ld_data = 8'h99;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || n_cmp !== 16'd0 || n_lit !== 16'd0) begin
      fails++; $display("FAIL mid_async got v=%b cmp=%0d lit=%0d want 0 0 0", out_valid, n_cmp, n_lit); end
    tests++; if (dict_ready !== 1'b0 || tok_ready !== 1'b0 || dict_we !== 1'b0) begin
      fails++; $display("FAIL mid_ctrl got rdy=%b tok_rdy=%b we=%b want 0 0 0", dict_ready, tok_ready, dict_we); end
    #2;
    rst_n = 1'b1;
    tok_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (tok_ready !== 1'b0 || dict_we !== 1'b1) begin
      fails++; $display("FAIL mid_back_in_load got tok_rdy=%b we=%b want 0 1", tok_ready, dict_we); end
    ld_valid = 1'b0; tok_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_ignored_in_run();
    test_gap_and_early_tokens();
    test_expand();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dict_decompressor.md
Name: dict_decompressor

Overview:
- Downstream consumer and loader of the preloaded compression dictionary (KEY_WIDTH-bit key to VAL_WIDTH-bit value, combinational lookup, auto-incrementing write port).
- At startup it streams the dictionary contents into the write port. It then expands a stream of compressed tokens into uncompressed VAL_WIDTH words.
- Tokens are either a dictionary key (looked up combinationally) or a raw literal. Output is one registered stage with a valid/ready handshake toward fetch.

Parameters:
KEY_WIDTH, 4, dictionary index width; dictionary depth = 2**KEY_WIDTH
VAL_WIDTH, 8, uncompressed word width
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  load word present on ld_data
ld_data  in  VAL_WIDTH  dictionary entry to write
dict_we  out  1  to dictionary write_enable
dict_wval  out  VAL_WIDTH  to dictionary write_val
dict_key  out  KEY_WIDTH  to dictionary key_lookup_in
dict_val  in  VAL_WIDTH  from dictionary val_out (combinational)
dict_ready  out  1  dictionary fully loaded; RUN state
tok_valid  in  1  token present
tok_ready  out  1  token accepted this cycle when tok_valid&tok_ready
tok_cmp  in  1  1 = compressed (key in tok_data[KEY_WIDTH-1:0]); 0 = literal
tok_data  in  VAL_WIDTH  token payload
out_valid  out  1  expanded word valid
out_ready  in  1  downstream accepts
out_data  out  VAL_WIDTH  expanded word
out_was_cmp  out  1  word came from the dictionary
n_cmp  out  CNT_WIDTH  compressed tokens emitted
n_lit  out  CNT_WIDTH  literal tokens emitted

Behaviour:
- Reset (async, rst_n=0): state=LOAD, load count=0. Outputs dict_we=0, dict_ready=0, tok_ready=0, out_valid=0, out_data=0, out_was_cmp=0, n_cmp=0, n_lit=0.
- FSM has 2 states: LOAD and RUN. There is no path from RUN back to LOAD except reset.
- LOAD:
  - dict_we = ld_valid (combinational); dict_wval = ld_data.
  - On each cycle with ld_valid=1: count += 1.
  - A cycle with ld_valid=0 while 0 < count < 2**KEY_WIDTH resets count to 0. The dictionary resets its write index when write enable drops, so a partial load restarts from entry 0 and upstream must resend from entry 0.
  - When ld_valid=1 and count == 2**KEY_WIDTH-1 (the last entry is written this cycle), go to RUN at the next edge.
  - In RUN, dict_we=0 regardless of ld_valid, and ld_data is ignored.
  - tok_ready=0 throughout LOAD.
- RUN:
  - dict_ready=1.
  - dict_key = tok_data[KEY_WIDTH-1:0] combinationally at all times, independent of tok_cmp.
  - tok_ready = !out_valid | out_ready. This gives full throughput with a single output register and a combinational ready path.
  - On acceptance (tok_valid & tok_ready):
    - out_data <= tok_cmp ? dict_val : tok_data; out_was_cmp <= tok_cmp; out_valid <= 1.
    - The n_cmp or n_lit counter increments, saturating at all-ones.
  - Latency: token to out_valid is 1 cycle.
  - If out_valid & out_ready and there is no acceptance, out_valid <= 0.
  - Simultaneous drain and accept: out_valid stays 1 and the register loads the new word.
  - While out_valid=1 and out_ready=0, out_data and out_was_cmp are held stable and tok_ready=0.
- Literal tokens never consult the dictionary. Upper tok_data bits of a compressed token are ignored.
- Reset asserted mid-operation:
  - Everything returns to reset values immediately; any pending out word is dropped.
  - The dictionary must be reloaded; its write index restarts because dict_we drops.

Test Plan:
- Load: hold ld_valid=1 for 16 cycles with ld_data = 8'h10 + i. Required: dict_we high exactly 16 cycles, dict_ready=1 on the 17th cycle, tok_ready rises with it.
- Gap in load: ld_valid drops after 5 words, then 16 contiguous words. Required: dict_ready only after the 16 contiguous words; dictionary entry 0 = first word of the second burst.
- Expand: after loading entry 3 = 8'hA5, send token cmp=1 data=8'h03, then literal 8'h7E with out_ready=1. Required: out_data = A5 (was_cmp=1), then 7E (was_cmp=0) on consecutive cycles; n_cmp=1, n_lit=1.
- Backpressure: out_ready=0 for 4 cycles with tokens pending. Required: tok_ready=0 and out_data held; when out_ready rises, the next token is accepted the same cycle and no word is lost or duplicated.
- Tokens before load: tok_valid=1 during LOAD. Required: tok_ready=0, out_valid=0, counters stay 0.
- Reset mid-stream: rst_n low while out_valid=1. Required: out_valid=0 and counters=0 immediately (asynchronous), state back to LOAD, dict_ready=0.
